// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle adder/subtractor that consumes a WIDTH-bit
// operand pair DIGIT bits per clock, low digit first. Subtraction is done as
// a + ~b + 1 by inverting b on accept and seeding the carry with mode.
// Result and flags are registered and only change on the commit edge.
//
// Handshake: start is sampled only while ready=1. The edge that samples
// ready=1 && start=1 accepts the operation (a, b and mode are latched there),
// and ready drops on that same edge. done is a single-cycle pulse that is
// high in the cycle after the commit edge. ready is high again in that same
// cycle, so a start held through the done cycle is accepted on the next edge.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [0:0]       dbg_state_o
);

    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Reject parameter sets where the operand does not split into whole digits.
    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("addsub_serial: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    logic [0:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             carry_q,  carry_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;

    // One digit of the ripple: low DIGIT bits of each operand plus carry in.
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_shift;
    logic                   last_digit;

    assign dsum       = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_q};
    // New sum digit enters from the top; after N steps the low digit has
    // travelled down to bit 0. The wide concatenation keeps DIGIT == WIDTH legal.
    assign acc_cat    = {dsum[DIGIT-1:0], acc_q};
    assign acc_shift  = acc_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_digit = (cnt_q == CW'(N - 1));

    // Next-state logic for the control FSM and the serial datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{mode}};
                    acc_d   = '0;
                    carry_d = mode;
                    // Sign bits are kept aside because the shift registers
                    // no longer hold them by the time the overflow is judged.
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1] ^ mode;
                end
            end
            S_RUN: begin
                acc_d   = acc_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last_digit) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    result_d = acc_shift;
                    cout_d   = dsum[DIGIT];
                    ovf_d    = (a_msb_q == b_msb_q) && (acc_shift[WIDTH-1] != a_msb_q);
                    zero_d   = (acc_shift == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over every other update, including commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (DIGIT=2, 1, 8 at WIDTH=8) share
// clk/rst/a/b/mode and each has its own start. A cycle-level model computes
// expected outputs from plain arithmetic; directed vectors carry literal
// expected results checked whenever done pulses.
module tb_addsub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;

    logic       rdy_w  [3];
    logic       done_w [3];
    logic [7:0] res_w  [3];
    logic       cout_w [3];
    logic       ovf_w  [3];
    logic       zero_w [3];
    logic [0:0] st_w   [3];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [10:0] exp_q[$];   // literal expectations: {zero, ovf, cout, result}

    // Clock
    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .a(a), .b(b),
        .ready(rdy_w[0]), .done(done_w[0]), .result(res_w[0]), .cout(cout_w[0]),
        .ovf(ovf_w[0]), .zero(zero_w[0]), .dbg_state_o(st_w[0]));

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .a(a), .b(b),
        .ready(rdy_w[1]), .done(done_w[1]), .result(res_w[1]), .cout(cout_w[1]),
        .ovf(ovf_w[1]), .zero(zero_w[1]), .dbg_state_o(st_w[1]));

    addsub_serial #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .a(a), .b(b),
        .ready(rdy_w[2]), .done(done_w[2]), .result(res_w[2]), .cout(cout_w[2]),
        .ovf(ovf_w[2]), .zero(zero_w[2]), .dbg_state_o(st_w[2]));

    function automatic int n_of(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    // Reference arithmetic: unsigned for result/carry, signed range for overflow.
    function automatic logic [10:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                           input logic m);
        int ux, uy, sx, sy, s, ss;
        logic [7:0] r;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!m) begin
            s  = ux + uy;
            ss = sx + sy;
            c  = (s > 255);
        end else begin
            s  = ux - uy;
            ss = sx - sy;
            c  = (ux >= uy);
        end
        r = s[7:0];
        o = (ss > 127) || (ss < -128);
        return {(r == 8'h00), o, c, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, want);
        end
    endtask

    // Behavioural model state
    logic        m_busy [3] = '{1'b0, 1'b0, 1'b0};
    int          m_rem  [3] = '{0, 0, 0};
    logic [7:0]  m_a    [3];
    logic [7:0]  m_b    [3];
    logic        m_mode [3];
    logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
    logic [10:0] m_out  [3] = '{11'h0, 11'h0, 11'h0};

    // Model: one operation occupies N cycles, then publishes its result with done.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_rem[i]  <= 0;
                m_done[i] <= 1'b0;
                m_out[i]  <= 11'h0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (m_rem[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_out[i]  <= ref_op(m_a[i], m_b[i], m_mode[i]);
                    end else begin
                        m_rem[i] <= m_rem[i] - 1;
                    end
                end else if (start_v[i]) begin
                    m_busy[i] <= 1'b1;
                    m_rem[i]  <= n_of(i);
                    m_a[i]    <= a;
                    m_b[i]    <= b;
                    m_mode[i] <= mode;
                end
            end
        end
    end

    // Scoreboard: model comparison every cycle, literal expectations on done.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("ready[%0d]", i), {31'b0, rdy_w[i]}, {31'b0, !m_busy[i]});
                chk($sformatf("done[%0d]", i), {31'b0, done_w[i]}, {31'b0, m_done[i]});
                chk($sformatf("outs[%0d]", i),
                    {21'b0, zero_w[i], ovf_w[i], cout_w[i], res_w[i]}, {21'b0, m_out[i]});
                chk($sformatf("state[%0d]", i), {31'b0, (st_w[i] != 1'b0)}, {31'b0, m_busy[i]});
                if (done_w[i] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_done[%0d]", i), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("literal[%0d]", i),
                            {21'b0, zero_w[i], ovf_w[i], cout_w[i], res_w[i]},
                            {21'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Waits (bounded) for done on instance i; optionally pokes start and
    // scrambles operands during RUN. Returns cycles since the accept edge.
    task automatic wait_done(input int i, input bit poke, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done_w[i] === 1'b1) break;
            if (poke && lat == 1) begin
                start_v[i] = 1'b1;
                a = 8'hFF;
                b = 8'hFF;
                mode = 1'b1;
            end
            if (poke && lat == 2) start_v[i] = 1'b0;
        end
    endtask

    // Driver: one operation from a negedge with the DUT idle, ending in the done cycle.
    task automatic run_op(input int i, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tm, input logic [10:0] want);
        int lat;
        exp_q.push_back(want);
        a = ta;
        b = tb_v;
        mode = tm;
        start_v[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[i] = 1'b0;
        wait_done(i, 1'b0, lat);
        chk($sformatf("latency[%0d]", i), lat, n_of(i));
    endtask

    initial begin
        int lat;
        int pulses;
        rst = 1'b1;
        start_v = 3'b111;
        mode = 1'b0;
        a = 8'h55;
        b = 8'h11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ready", {31'b0, rdy_w[0]}, 32'd1);
        chk("reset_done", {31'b0, done_w[0]}, 32'd0);
        chk("reset_outs", {21'b0, zero_w[0], ovf_w[0], cout_w[0], res_w[0]}, 32'd0);
        rst = 1'b0;
        start_v = 3'b000;
        @(negedge clk);

        // DIGIT=2 directed vectors: {zero, ovf, cout, result}
        run_op(0, 8'h3C, 8'h05, 1'b0, {1'b0, 1'b0, 1'b0, 8'h41});
        run_op(0, 8'hFF, 8'h01, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
        run_op(0, 8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 1'b0, 8'h80});
        run_op(0, 8'h04, 8'h06, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFE});
        run_op(0, 8'h80, 8'h01, 1'b1, {1'b0, 1'b1, 1'b1, 8'h7F});
        run_op(0, 8'h05, 8'h05, 1'b1, {1'b1, 1'b0, 1'b1, 8'h00});

        // start and operands disturbed during RUN: original result on time
        exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h46});
        a = 8'h12; b = 8'h34; mode = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 1'b1, lat);
        chk("latency_poke", lat, 4);

        // Back-to-back: start held through RUN and the done cycle
        exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h08});
        exp_q.push_back({1'b0, 1'b0, 1'b0, 8'hF0});
        a = 8'h05; b = 8'h03; mode = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h10; b = 8'h20; mode = 1'b1;
        wait_done(0, 1'b0, lat);
        chk("latency_b2b_1", lat, 4);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_accepted", {31'b0, rdy_w[0]}, 32'd0);
        start_v[0] = 1'b0;
        wait_done(0, 1'b0, lat);
        chk("latency_b2b_2", lat, 4);

        // Reset during the 2nd RUN cycle abandons the operation
        a = 8'h21; b = 8'h10; mode = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'b0, rdy_w[0]}, 32'd1);
        chk("midrst_result", {24'b0, res_w[0]}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (done_w[0] === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("midrst_no_done", pulses, 0);

        // DIGIT=1 (N=8)
        run_op(1, 8'h3C, 8'h05, 1'b0, {1'b0, 1'b0, 1'b0, 8'h41});
        run_op(1, 8'h80, 8'h01, 1'b1, {1'b0, 1'b1, 1'b1, 8'h7F});
        run_op(1, 8'hA5, 8'h5B, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
        // DIGIT=8 (N=1)
        run_op(2, 8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 1'b0, 8'h80});
        run_op(2, 8'h04, 8'h06, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFE});
        run_op(2, 8'hC8, 8'h64, 1'b1, {1'b0, 1'b1, 1'b1, 8'h64});

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "time limit");
    end

endmodule
